// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction queue between the fetch stage (I-cache output) and decode.
//   Every valid {pc, inst} delivered by fetch is captured and presented to
//   decode in arrival order. Decode stalls are absorbed, and fetch_stall is
//   raised one entry early so that the request already in flight in the
//   I-cache still has a slot. A flush empties the queue in one cycle.
//
// Ports
//   clk          in   1      clock, all state on posedge
//   reset        in   1      synchronous, active-high
//   in_e_        in   1      fetch -> buffer valid, active-low
//   in_pc        in   ADDR   PC of incoming instruction
//   in_inst      in   INST   incoming instruction
//   fetch_stall  out  1      stop issuing fetch requests
//   out_e_       out  1      buffer -> decode valid, active-low (1 = empty)
//   out_pc       out  ADDR   PC of head entry
//   out_inst     out  INST   head instruction
//   dec_stall    in   1      decode cannot accept this cycle
//   flush_       in   1      active-low, drop all entries
//   count        out  CNT    current occupancy (0..DEPTH)
//   overflow     out  1      sticky: push attempted while full with no pop
// -----------------------------------------------------------------------------
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef InstWidth
`define InstWidth 32
`endif

module fetch_buffer #(
  parameter  int ADDR  = `AddrWidth,
  parameter  int INST  = `InstWidth,
  parameter  int DEPTH = 4,
  localparam int CNT   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_e_,
  input  logic [ADDR-1:0] in_pc,
  input  logic [INST-1:0] in_inst,
  output logic            fetch_stall,
  output logic            out_e_,
  output logic [ADDR-1:0] out_pc,
  output logic [INST-1:0] out_inst,
  input  logic            dec_stall,
  input  logic            flush_,
  output logic [CNT-1:0]  count,
  output logic            overflow
);

  localparam int PTRW = $clog2(DEPTH);

  logic [ADDR-1:0] pc_q   [DEPTH];
  logic [INST-1:0] inst_q [DEPTH];

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT-1:0]  count_q, count_d;
  logic            overflow_q, overflow_d;

  logic empty, full, push, pop, flush, wr_en;

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT'(DEPTH));
    flush = !flush_;
    pop   = !empty && !dec_stall;
    // A full queue can still accept when the head leaves in the same cycle.
    push  = !in_e_ && (!full || pop);
    wr_en = push && !flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Flush wins over same-cycle push/pop; overflow history is kept.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT'(1);
        2'b01:   count_d = count_q - CNT'(1);
        default: count_d = count_q;
      endcase
      // Dropped instruction: valid arrived while full and nothing left.
      if (!in_e_ && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero afterwards.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        pc_q[gi]   <= '0;
        inst_q[gi] <= '0;
      end else if (wr_en && (wr_ptr_q == PTRW'(gi))) begin
        pc_q[gi]   <= in_pc;
        inst_q[gi] <= in_inst;
      end
    end
  end

  // Head is read combinationally; payload is stale when empty, gated by out_e_.
  assign out_e_      = empty;
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_inst    = inst_q[rd_ptr_q];
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign fetch_stall = (count_q >= CNT'(DEPTH - 1));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_e_;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        fetch_stall;
  logic        out_e_;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        dec_stall;
  logic        flush_;
  logic [2:0]  count;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  logic exp_ovf = 1'b0;

  fetch_buffer #(.ADDR(32), .INST(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_e_      (in_e_),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .fetch_stall(fetch_stall),
    .out_e_     (out_e_),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .dec_stall  (dec_stall),
    .flush_     (flush_),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return ~pc ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs (we sit at a negedge), check outputs against the
  // scoreboard, update the model for the coming edge, then advance.
  task automatic step(input bit valid, input logic [31:0] pc, input bit stall, input bit flush);
    bit mpop, mpush, mfull;
    in_e_     = !valid;
    in_pc     = pc;
    in_inst   = inst_of(pc);
    dec_stall = stall;
    flush_    = !flush;
    #1;
    chk("out_e_",      32'(out_e_),      32'(exp_q.size() == 0));
    chk("count",       32'(count),       32'(exp_q.size()));
    chk("fetch_stall", 32'(fetch_stall), 32'(exp_q.size() >= DEPTH - 1));
    chk("overflow",    32'(overflow),    32'(exp_ovf));
    if (exp_q.size() != 0) begin
      chk("head_pc",   out_pc,   exp_q[0].pc);
      chk("head_inst", out_inst, exp_q[0].inst);
    end
    if (!stall && exp_q.size() != 0)
      $display("[TB] decode takes pc=%0h inst=%0h", out_pc, out_inst);
    mfull = (exp_q.size() == DEPTH);
    mpop  = (exp_q.size() != 0) && !stall;
    mpush = valid && (!mfull || mpop);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (valid && mfull && !mpop) exp_ovf = 1'b1;
      if (mpop)  void'(exp_q.pop_front());
      if (mpush) exp_q.push_back('{pc: pc, inst: inst_of(pc)});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_e_ = 1'b1; in_pc = '0; in_inst = '0;
    dec_stall = 1'b0; flush_ = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_count",    32'(count),       32'd0);
    chk("rst_out_e_",   32'(out_e_),      32'd1);
    chk("rst_fstall",   32'(fetch_stall), 32'd0);
    chk("rst_overflow", 32'(overflow),    32'd0);
    chk("rst_out_pc",   out_pc,           32'd0);
    chk("rst_out_inst", out_inst,         32'd0);

    // 1: three pushes, no stall; decode sees them on consecutive cycles
    step(1, 32'h100, 0, 0);
    step(1, 32'h104, 0, 0);
    step(1, 32'h108, 0, 0);
    step(0, 32'h0,   0, 0);

    // 2: decode stalled, push every cycle from empty; 4th push is the in-flight one
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 1, 0);
    chk("t2_count",    32'(count),       32'd4);
    chk("t2_overflow", 32'(overflow),    32'd0);
    chk("t2_head",     out_pc,           32'h100);
    chk("t2_fstall",   32'(fetch_stall), 32'd1);

    // 3: full, push+pop every cycle across pointer wrap, then drain
    for (int i = 0; i < 8; i++) step(1, 32'h200 + 32'(4 * i), 0, 0);
    chk("t3_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0);

    // 4: count=2, flush with concurrent push and pop
    step(1, 32'h300, 1, 0);
    step(1, 32'h304, 1, 0);
    step(1, 32'h308, 0, 1);
    chk("t4_count",  32'(count),  32'd0);
    chk("t4_out_e_", 32'(out_e_), 32'd1);
    step(1, 32'h400, 1, 0);
    chk("t4_head", out_pc, 32'h400);
    step(0, 32'h0, 0, 0);

    // 5: full with decode stalled, push -> overflow sticky, contents unchanged
    for (int i = 0; i < 4; i++) step(1, 32'h500 + 32'(4 * i), 1, 0);
    step(1, 32'h510, 1, 0);
    chk("t5_overflow", 32'(overflow), 32'd1);
    chk("t5_count",    32'(count),    32'd4);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0);
    chk("t5_sticky", 32'(overflow), 32'd1);

    // 6: count=3, reset and flush together
    for (int i = 0; i < 3; i++) step(1, 32'h600 + 32'(4 * i), 1, 0);
    reset = 1'b1; flush_ = 1'b0; in_e_ = 1'b0; in_pc = 32'h700; in_inst = inst_of(32'h700);
    @(posedge clk); @(negedge clk);
    reset = 1'b0; flush_ = 1'b1; in_e_ = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("t6_count",    32'(count),       32'd0);
    chk("t6_overflow", 32'(overflow),    32'd0);
    chk("t6_out_e_",   32'(out_e_),      32'd1);
    chk("t6_fstall",   32'(fetch_stall), 32'd0);
    chk("t6_out_pc",   out_pc,           32'd0);
    step(0, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
